// File: rtl/trace_capture_pkg.sv
// Shared definitions for the trace capture block: FSM states, trigger modes,
// register word offsets and configuration reset values.
package trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TM_EQ     = 2'd0,  // masked trig_i equals TRIG_VALUE
    TM_NE     = 2'd1,  // masked trig_i differs from TRIG_VALUE
    TM_CHANGE = 2'd2,  // masked trig_i changed since the previous stored sample
    TM_FIRST  = 2'd3   // first stored sample after ARM
  } trig_mode_e;

  // Register word offsets (wb_adr_i[7:2]).
  localparam logic [5:0] REG_CTRL         = 6'h00;
  localparam logic [5:0] REG_STATUS       = 6'h01;
  localparam logic [5:0] REG_TRIG_VALUE   = 6'h02;
  localparam logic [5:0] REG_TRIG_MASK    = 6'h03;
  localparam logic [5:0] REG_TRIG_MODE    = 6'h04;
  localparam logic [5:0] REG_POST_COUNT   = 6'h05;
  localparam logic [5:0] REG_TRIG_POS     = 6'h06;
  localparam logic [5:0] REG_SAMPLE_COUNT = 6'h07;

  localparam int POST_COUNT_RST = 32;

endpackage

// File: rtl/trace_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module trace_capture_ram #(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write on capture, read registered every cycle.
  // NOTE: neither the array nor the read register is reset, so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture.sv
// Trace logger: captures {trig_i, data_i} into a circular RAM, stops a programmable
// number of samples after a masked trigger and presents the window oldest-first
// through a Wishbone slave port.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic [23:2]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  input  logic [31:0]           trig_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  sample_en_i,
  output logic                  trig_o,
  output logic                  done_o
);

  localparam int DEPTH  = 2**DEPTH_LOG2;
  localparam int NLANES = 1 + DATA_WIDTH/32;
  localparam int RAM_W  = 32 + DATA_WIDTH;
  localparam int LANE_W = 21 - DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] POST_MAX = DEPTH_LOG2'(DEPTH-1);
  localparam logic [DEPTH_LOG2-1:0] POST_RST =
    (POST_COUNT_RST > DEPTH-1) ? POST_MAX : DEPTH_LOG2'(POST_COUNT_RST);
  localparam logic [DEPTH_LOG2:0] SC_MAX = (DEPTH_LOG2+1)'(DEPTH);

  state_e                  state;
  trig_mode_e              trig_mode, mode_act;
  logic [31:0]             trig_value, trig_mask, prev_trig;
  logic                    prev_valid;
  logic [DEPTH_LOG2-1:0]   post_count, post_left, wr_ptr, rd_addr, trig_pos;
  logic [DEPTH_LOG2:0]     sample_count;
  logic                    mem_pend;
  logic [LANE_W-1:0]       lane_q;
  logic [RAM_W-1:0]        ram_q;
  logic [31:0]             reg_rdata, lane_word, diff_v, diff_p;
  logic                    req, start, is_mem, reg_wr, cfg_ok, arm_req, abort_req;
  logic                    capturing, sample_fire, trig_match, hit;
  logic [5:0]              reg_idx;
  logic                    unused_sel;

  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign unused_sel = ^wb_sel_i;

  // Bus request decode: a new access starts only when no ack or RAM read is in flight.
  assign req       = wb_cyc_i & wb_stb_i;
  assign start     = req & ~wb_ack_o & ~mem_pend;
  assign is_mem    = wb_adr_i[23];
  assign reg_idx   = wb_adr_i[7:2];
  assign reg_wr    = start & wb_we_i & ~is_mem;
  assign cfg_ok    = (state == ST_IDLE) || (state == ST_DONE);
  assign arm_req   = reg_wr && (reg_idx == REG_CTRL) && wb_dat_i[0] && !wb_dat_i[1];
  assign abort_req = reg_wr && (reg_idx == REG_CTRL) && wb_dat_i[1];

  assign capturing   = (state == ST_ARMED) || (state == ST_POST);
  assign sample_fire = sample_en_i & capturing;
  assign hit         = (state == ST_ARMED) & sample_en_i & trig_match;
  assign trig_pos    = POST_MAX - post_count;

  // Entry k of the window lives at the slot just after the newest sample, offset by k.
  assign rd_addr = wr_ptr + wb_adr_i[DEPTH_LOG2+1:2];

  trace_capture_ram #(.WIDTH(RAM_W), .ADDR_W(DEPTH_LOG2)) u_ram (
    .clk   (wb_clk_i),
    .we    (sample_fire),
    .waddr (wr_ptr),
    .wdata ({trig_i, data_i}),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Trigger comparator for the mode latched at ARM.
  always_comb begin
    diff_v = (trig_i ^ trig_value) & trig_mask;
    diff_p = (trig_i ^ prev_trig) & trig_mask;
    trig_match = 1'b0;
    case (mode_act)
      TM_EQ:     trig_match = (diff_v == '0);
      TM_NE:     trig_match = (diff_v != '0);
      TM_CHANGE: trig_match = prev_valid && (diff_p != '0);
      TM_FIRST:  trig_match = !prev_valid;
      default:   trig_match = 1'b0;
    endcase
  end

  // Register read mux; CTRL reads back as STATUS.
  always_comb begin
    case (reg_idx)
      REG_CTRL, REG_STATUS: reg_rdata = {30'd0, state};
      REG_TRIG_VALUE:       reg_rdata = trig_value;
      REG_TRIG_MASK:        reg_rdata = trig_mask;
      REG_TRIG_MODE:        reg_rdata = {30'd0, trig_mode};
      REG_POST_COUNT:       reg_rdata = 32'(post_count);
      REG_TRIG_POS:         reg_rdata = 32'(trig_pos);
      REG_SAMPLE_COUNT:     reg_rdata = 32'(sample_count);
      default:              reg_rdata = 32'd0;
    endcase
  end

  // Lane select on the registered RAM word; lane 0 is the trigger word at the top.
  always_comb begin
    lane_word = 32'd0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_q == LANE_W'(i)) lane_word = ram_q[(NLANES-1-i)*32 +: 32];
    end
  end

  // Wishbone slave: single-cycle register access, two-cycle RAM read, configuration writes.
  // NOTE: every flop below uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 32'd0;
      mem_pend   <= 1'b0;
      lane_q     <= '0;
      trig_value <= 32'd0;
      trig_mask  <= 32'hFFFF_FFFF;
      trig_mode  <= TM_EQ;
      post_count <= POST_RST;
    end else begin
      wb_ack_o <= 1'b0;
      if (mem_pend) begin
        // A master that dropped the cycle gets no late ack.
        mem_pend <= 1'b0;
        if (req) begin
          wb_ack_o <= 1'b1;
          wb_dat_o <= lane_word;
        end
      end else if (start) begin
        if (is_mem && !wb_we_i) begin
          mem_pend <= 1'b1;
          lane_q   <= wb_adr_i[22:DEPTH_LOG2+2];
        end else begin
          wb_ack_o <= 1'b1;
          if (!wb_we_i) wb_dat_o <= reg_rdata;
        end
        if (reg_wr && cfg_ok) begin
          case (reg_idx)
            REG_TRIG_VALUE: trig_value <= wb_dat_i;
            REG_TRIG_MASK:  trig_mask  <= wb_dat_i;
            REG_TRIG_MODE:  trig_mode  <= trig_mode_e'(wb_dat_i[1:0]);
            REG_POST_COUNT: post_count <= (wb_dat_i >= 32'(DEPTH)) ? POST_MAX
                                          : wb_dat_i[DEPTH_LOG2-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Capture FSM with pointer, counters and registered trig_o/done_o.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state        <= ST_IDLE;
      trig_o       <= 1'b0;
      done_o       <= 1'b0;
      wr_ptr       <= '0;
      sample_count <= '0;
      post_left    <= '0;
      prev_trig    <= 32'd0;
      prev_valid   <= 1'b0;
      mode_act     <= TM_EQ;
    end else begin
      trig_o <= 1'b0;
      if (sample_fire) wr_ptr <= wr_ptr + 1'b1;
      if (abort_req) begin
        state  <= ST_IDLE;
        done_o <= 1'b0;
      end else if (arm_req) begin
        state        <= ST_ARMED;
        done_o       <= 1'b0;
        sample_count <= '0;
        post_left    <= '0;
        prev_valid   <= 1'b0;
        mode_act     <= trig_mode;
      end else begin
        if (sample_fire) begin
          prev_trig  <= trig_i;
          prev_valid <= 1'b1;
          if (sample_count != SC_MAX) sample_count <= sample_count + 1'b1;
        end
        case (state)
          ST_ARMED: begin
            if (hit) begin
              trig_o <= 1'b1;
              if (post_count == '0) begin
                state  <= ST_DONE;
                done_o <= 1'b1;
              end else begin
                state     <= ST_POST;
                post_left <= post_count;
              end
            end
          end
          ST_POST: begin
            if (sample_en_i) begin
              post_left <= post_left - 1'b1;
              if (post_left == DEPTH_LOG2'(1)) begin
                state  <= ST_DONE;
                done_o <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: a bus master pushes expected read data and ack latency
// into a scoreboard queue, and a monitor pops and compares on every ack.
module tb_trace_capture;

  logic        clk;
  logic        wb_rst_ni;
  logic [23:2] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0] trig_i;
  logic [95:0] data_i;
  logic        sample_en_i;
  logic        trig_o, done_o;

  trace_capture #(.DATA_WIDTH(96), .DEPTH_LOG2(10)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (wb_rst_ni),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_i    (wb_sel_i),
    .wb_we_i     (wb_we_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_err_o    (wb_err_o),
    .wb_rty_o    (wb_rty_o),
    .trig_i      (trig_i),
    .data_i      (data_i),
    .sample_en_i (sample_en_i),
    .trig_o      (trig_o),
    .done_o      (done_o)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    bit          chk;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  int   cyc_n;
  int   trig_cnt;
  int   tc0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] ramp(input int s);
    return {32'(s), 32'(s) ^ 32'hFFFF_0000, 32'h8000_0000 + 32'(s)};
  endfunction

  function automatic logic [21:0] reg_a(input int idx);
    return 22'(idx);
  endfunction

  function automatic logic [21:0] mem_a(input int lane, input int k);
    return 22'(32'h0020_0000 | (lane << 10) | k);
  endfunction

  // One bus access; the monitor checks data and latency, this task only bounds the wait.
  task automatic wb_xfer(input logic [21:0] adr, input logic we, input logic [31:0] wdat,
                         input string name, input logic [31:0] exp, input bit chk, input int lat);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    e.name = name; e.data = exp; e.chk = chk; e.lat = lat; e.t0 = cyc_n;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got = 1'b1; break; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_back());
    end
  endtask

  task automatic reg_wr(input int idx, input logic [31:0] d);
    wb_xfer(reg_a(idx), 1'b1, d, "reg_wr", 32'd0, 1'b0, 1);
  endtask

  task automatic reg_rd(input string nm, input int idx, input logic [31:0] e);
    wb_xfer(reg_a(idx), 1'b0, 32'd0, nm, e, 1'b1, 1);
  endtask

  task automatic mem_rd(input string nm, input int lane, input int k, input logic [31:0] e);
    wb_xfer(mem_a(lane, k), 1'b0, 32'd0, nm, e, 1'b1, 2);
  endtask

  task automatic drive(input logic [31:0] t, input logic [95:0] d, input logic en);
    @(posedge clk); #1;
    trig_i = t; data_i = d; sample_en_i = en;
  endtask

  initial begin
    bit acked;
    n_vec = 0; n_err = 0; cyc_n = 0; trig_cnt = 0;
    wb_rst_ni = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    trig_i = '0; data_i = '0; sample_en_i = 1'b0;

    // Monitor: pops the scoreboard on every ack and counts trig_o pulses.
    fork
      forever begin
        @(negedge clk);
        if (wb_rst_ni && trig_o) trig_cnt++;
        if (wb_rst_ni && wb_ack_o) begin
          if (sb.size() == 0) begin
            check("stray_ack", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_lat"}, 32'(cyc_n - e.t0), 32'(e.lat));
            if (e.chk) check(e.name, wb_dat_o, e.data);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_trig", {31'd0, trig_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_err_rty", {30'd0, wb_err_o, wb_rty_o}, 32'd0);
    wb_rst_ni = 1'b1;
    reg_rd("rst_status", 1, 32'd0);
    reg_rd("rst_value", 2, 32'd0);
    reg_rd("rst_mask", 3, 32'hFFFF_FFFF);
    reg_rd("rst_mode", 4, 32'd0);
    reg_rd("rst_post", 5, 32'd32);
    reg_rd("rst_trigpos", 6, 32'd991);

    // Test 1: mode 0, V=A5 M=FF, POST=32, trigger at sample 600 of a ramp
    reg_wr(2, 32'hA5);
    reg_wr(3, 32'hFF);
    reg_wr(0, 32'h1);
    tc0 = trig_cnt;
    for (int i = 0; i < 633; i++) begin
      drive((i == 600) ? 32'hA5 : (32'(i) << 8), ramp(i), 1'b1);
      if (i == 600) check("t1_trig_pre", {31'd0, trig_o}, 32'd0);
      if (i == 601) check("t1_trig_o", {31'd0, trig_o}, 32'd1);
      if (i == 632) check("t1_done_early", {31'd0, done_o}, 32'd0);
    end
    drive(32'd0, 96'd0, 1'b0);
    check("t1_done", {31'd0, done_o}, 32'd1);
    reg_rd("t1_status", 1, 32'd3);
    reg_rd("t1_ctrl_rd", 0, 32'd3);
    reg_rd("t1_count", 7, 32'd633);
    reg_rd("t1_trigpos", 6, 32'd991);
    mem_rd("t1_e991_l0", 0, 991, 32'hA5);
    mem_rd("t1_e992_l0", 0, 992, 32'(601) << 8);
    mem_rd("t1_e991_l1", 1, 991, 32'd600);
    mem_rd("t1_e1023_l1", 1, 1023, 32'd632);
    mem_rd("t1_e1023_l2", 2, 1023, 32'd632 ^ 32'hFFFF_0000);
    mem_rd("t1_e1023_l3", 3, 1023, 32'h8000_0000 + 32'd632);
    mem_rd("t1_e391_l1", 1, 391, 32'd0);
    mem_rd("t1_e500_l3", 3, 500, 32'h8000_0000 + 32'd109);
    mem_rd("t1_lane4", 4, 1023, 32'd0);
    wb_xfer(mem_a(1, 1023), 1'b1, 32'hDEAD_BEEF, "t1_mem_wr", 32'd0, 1'b0, 1);
    mem_rd("t1_memwr_discard", 1, 1023, 32'd632);
    check("t1_trig_cnt", 32'(trig_cnt - tc0), 32'd1);

    // Aborted memory read: cycle dropped before ack, no ack may follow
    @(posedge clk); #1;
    wb_adr_i = mem_a(1, 1000); wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) acked = 1'b1;
    end
    check("abort_no_ack", {31'd0, acked}, 32'd0);

    // Test 2: mode 3, POST=5
    reg_wr(4, 32'd3);
    reg_wr(5, 32'd5);
    reg_wr(0, 32'h1);
    tc0 = trig_cnt;
    for (int j = 0; j < 6; j++) begin
      drive(32'h1000 + 32'(j), ramp(1000 + j), 1'b1);
      if (j == 1) check("t2_trig_o", {31'd0, trig_o}, 32'd1);
      if (j == 5) check("t2_done_early", {31'd0, done_o}, 32'd0);
    end
    drive(32'd0, 96'd0, 1'b0);
    check("t2_done", {31'd0, done_o}, 32'd1);
    reg_rd("t2_count", 7, 32'd6);
    reg_rd("t2_trigpos", 6, 32'd1018);
    mem_rd("t2_e1018_l0", 0, 1018, 32'h1000);
    mem_rd("t2_e1018_l1", 1, 1018, 32'd1000);
    mem_rd("t2_e1023_l1", 1, 1023, 32'd1005);
    check("t2_trig_cnt", 32'(trig_cnt - tc0), 32'd1);

    // Test 3: mode 2, M=1, POST=0; bit1 toggles must not fire, bit0 change fires
    reg_wr(4, 32'd2);
    reg_wr(3, 32'h1);
    reg_wr(5, 32'd0);
    reg_wr(0, 32'h1);
    tc0 = trig_cnt;
    drive(32'h0, ramp(2000), 1'b1);
    drive(32'h2, ramp(2001), 1'b1);
    drive(32'h0, ramp(2002), 1'b1);
    drive(32'h2, ramp(2003), 1'b1);
    check("t3_no_hit_bit1", {31'd0, trig_o}, 32'd0);
    drive(32'h3, ramp(2004), 1'b1);
    drive(32'd0, 96'd0, 1'b0);
    check("t3_trig_o", {31'd0, trig_o}, 32'd1);
    check("t3_done", {31'd0, done_o}, 32'd1);
    reg_rd("t3_count", 7, 32'd5);
    reg_rd("t3_trigpos", 6, 32'd1023);
    mem_rd("t3_e1023_l0", 0, 1023, 32'h3);
    mem_rd("t3_e1022_l0", 0, 1022, 32'h2);
    check("t3_trig_cnt", 32'(trig_cnt - tc0), 32'd1);

    // Test 4: sample_en 1-in-3, POST=4; gaps carry a matching trigger but are ignored
    reg_wr(4, 32'd0);
    reg_wr(3, 32'hFF);
    reg_wr(5, 32'd4);
    reg_wr(0, 32'h1);
    tc0 = trig_cnt;
    for (int c = 0; c < 21; c++) begin
      if (c % 3 == 0)
        drive((c / 3 == 2) ? 32'hA5 : 32'h0, {32'h100 + 32'(c / 3), 64'd0}, 1'b1);
      else
        drive(32'hA5, {32'hDEAD_0000 + 32'(c), 64'd0}, 1'b0);
    end
    drive(32'd0, 96'd0, 1'b0);
    check("t4_done", {31'd0, done_o}, 32'd1);
    reg_rd("t4_count", 7, 32'd7);
    mem_rd("t4_e1023_l1", 1, 1023, 32'h106);
    mem_rd("t4_e1022_l1", 1, 1022, 32'h105);
    mem_rd("t4_e1017_l1", 1, 1017, 32'h100);
    mem_rd("t4_e1019_l0", 0, 1019, 32'hA5);
    mem_rd("t4_e1018_l0", 0, 1018, 32'h0);
    check("t4_trig_cnt", 32'(trig_cnt - tc0), 32'd1);

    // Test 5: POST clamp, config lock while ARMED, ARM|ABORT
    reg_wr(5, 32'hFFFF);
    reg_rd("t5_post_clamp", 5, 32'd1023);
    reg_rd("t5_trigpos", 6, 32'd0);
    reg_wr(0, 32'h1);
    reg_rd("t5_status_armed", 1, 32'd1);
    reg_wr(2, 32'h55);
    reg_rd("t5_value_locked", 2, 32'hA5);
    reg_wr(0, 32'h3);
    reg_rd("t5_status_abort", 1, 32'd0);

    // Test 6: reset while in POST
    reg_wr(5, 32'd10);
    reg_wr(0, 32'h1);
    drive(32'hA5, ramp(3000), 1'b1);
    drive(32'd0, 96'd0, 1'b0);
    reg_rd("t6_status_post", 1, 32'd2);
    @(posedge clk); #1;
    wb_rst_ni = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_done", {31'd0, done_o}, 32'd0);
    check("t6_rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("t6_rst_dat", wb_dat_o, 32'd0);
    wb_rst_ni = 1'b1;
    reg_rd("t6_status", 1, 32'd0);
    reg_rd("t6_value", 2, 32'd0);
    reg_rd("t6_mask", 3, 32'hFFFF_FFFF);
    reg_rd("t6_post", 5, 32'd32);
    reg_rd("t6_count", 7, 32'd0);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
